// File: rtl/memsys_pkg.sv
// Shared types and defaults for memory_system_mm: region and FSM encodings,
// default base addresses, index-width helper and the built-in ROM image.
package memsys_pkg;

    typedef enum logic [1:0] {
        REG_ROM  = 2'd0,
        REG_RAM  = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEF_ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] DEF_RAM_BASE = 32'h1001_0000;
    localparam logic [31:0] DEF_IO_BASE  = 32'hFFFF_0000;

    // Word-index width wide enough for the largest of three regions.
    function automatic int idx_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Built-in ROM contents: upper half tag, lower half word number.
    function automatic logic [31:0] rom_image(int idx);
        return {16'hC0DE, 16'(idx)};
    endfunction

endpackage

// File: rtl/memsys_decoder.sv
// Combinational address decoder: byte address -> region, word index and
// misalignment flag.
module memsys_decoder
    import memsys_pkg::*;
#(
    parameter int          ROM_DEPTH = 64,
    parameter int          RAM_DEPTH = 64,
    parameter int          IO_REGS   = 4,
    parameter logic [31:0] ROM_BASE  = DEF_ROM_BASE,
    parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
    parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
    parameter int          IDX_W     = idx_width(ROM_DEPTH, RAM_DEPTH, IO_REGS)
) (
    input  logic [31:0]      addr,
    output region_t          region,
    output logic [IDX_W-1:0] word_idx,
    output logic             misaligned
);

    localparam logic [31:0] ROM_BYTES = 32'(4 * ROM_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_DEPTH);
    localparam logic [31:0] IO_BYTES  = 32'(4 * IO_REGS);

    logic [31:0] rom_off;
    logic [31:0] ram_off;
    logic [31:0] io_off;
    logic [31:0] sel_off;

    // Unsigned wrap turns "addr below base" into a huge offset, so one
    // compare covers both bounds.
    assign rom_off = addr - ROM_BASE;
    assign ram_off = addr - RAM_BASE;
    assign io_off  = addr - IO_BASE;

    always_comb begin
        region  = REG_NONE;
        sel_off = '0;
        if (rom_off < ROM_BYTES) begin
            region  = REG_ROM;
            sel_off = rom_off;
        end else if (ram_off < RAM_BYTES) begin
            region  = REG_RAM;
            sel_off = ram_off;
        end else if (io_off < IO_BYTES) begin
            region  = REG_IO;
            sel_off = io_off;
        end
    end

    assign word_idx   = sel_off[IDX_W+1:2];
    assign misaligned = |addr[1:0];

    logic unused_off;
    assign unused_off = ^{sel_off[31:IDX_W+2], sel_off[1:0]};

endmodule

// File: rtl/memory_system_mm.sv
// Handshaked data-port slave decoding ROM, RAM and an I/O register bank with
// programmable wait states and byte-lane writes. Fault reporting is enabled
// by defining MEMSYS_FAULT_EN.
module memory_system_mm
    import memsys_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ROM_DEPTH   = 64,
    parameter int          RAM_DEPTH   = 64,
    parameter int          IO_REGS     = 4,
    parameter logic [31:0] ROM_BASE    = DEF_ROM_BASE,
    parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE,
    parameter logic [31:0] IO_BASE     = DEF_IO_BASE,
    parameter int          WAIT_STATES = 1,
    parameter              ROM_FILE    = "program.dat"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [31:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [3:0]              be_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    fault_o,
    output logic [IO_REGS*32-1:0]   io_o
);

    localparam int IDX_W  = idx_width(ROM_DEPTH, RAM_DEPTH, IO_REGS);
    localparam int ROM_AW = idx_width(ROM_DEPTH, 1, 1);
    localparam int RAM_AW = idx_width(RAM_DEPTH, 1, 1);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                  state_q;
    logic [3:0]              wait_cnt_q;
    logic                    we_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              be_q;
    region_t                 rd_sel_q;
    logic                    fault_q;
    logic [DATA_WIDTH-1:0]   rom_rd_q;
    logic [DATA_WIDTH-1:0]   ram_rd_q;
    logic [DATA_WIDTH-1:0]   io_rd_q;

    logic                    accept;
    logic                    enter_resp;
    logic                    cur_we;
    logic [31:0]             cur_addr;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic [3:0]              cur_be;
    region_t                 region;
    logic [IDX_W-1:0]        word_idx;
    logic                    misaligned;
    logic                    fault_c;
    logic                    do_write;
    logic [DATA_WIDTH-1:0]   io_rd_c;
    logic [ROM_AW-1:0]       rom_idx;
    logic [RAM_AW-1:0]       ram_idx;

    logic [DATA_WIDTH-1:0]   rom_mem [ROM_DEPTH];
    logic [DATA_WIDTH-1:0]   ram_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]   io_words [IO_REGS];

    // With zero wait states the commit happens on the acceptance edge, so
    // the live request fields must drive the decode while in IDLE.
    assign accept     = (state_q == S_IDLE) && req_i;
    assign enter_resp = ((state_q == S_WAIT) && (wait_cnt_q == 4'd0)) ||
                        (accept && (WAIT_STATES == 0));
    assign cur_we     = (state_q == S_IDLE) ? we_i    : we_q;
    assign cur_addr   = (state_q == S_IDLE) ? addr_i  : addr_q;
    assign cur_wdata  = (state_q == S_IDLE) ? wdata_i : wdata_q;
    assign cur_be     = (state_q == S_IDLE) ? be_i    : be_q;

    memsys_decoder #(
        .ROM_DEPTH (ROM_DEPTH),
        .RAM_DEPTH (RAM_DEPTH),
        .IO_REGS   (IO_REGS),
        .ROM_BASE  (ROM_BASE),
        .RAM_BASE  (RAM_BASE),
        .IO_BASE   (IO_BASE),
        .IDX_W     (IDX_W)
    ) u_decoder (
        .addr       (cur_addr),
        .region     (region),
        .word_idx   (word_idx),
        .misaligned (misaligned)
    );

`ifdef MEMSYS_FAULT_EN
    assign fault_c = (region == REG_NONE) || misaligned ||
                     (cur_we && (region == REG_ROM));
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign fault_c = 1'b0;
`endif

    assign do_write = enter_resp && cur_we && !fault_c && reset;
    assign rom_idx  = word_idx[ROM_AW-1:0];
    assign ram_idx  = word_idx[RAM_AW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            assign rom_mem[gi] = DATA_WIDTH'(rom_image(gi));
        end

        for (gi = 0; gi < IO_REGS; gi++) begin : g_io
            logic [31:0] io_reg_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    io_reg_q <= '0;
                end else if (do_write && (region == REG_IO) &&
                             (word_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cur_be[b]) io_reg_q[8*b +: 8] <= cur_wdata[8*b +: 8];
                    end
                end
            end

            assign io_o[32*gi +: 32] = io_reg_q;
            assign io_words[gi]      = io_reg_q;
        end
    endgenerate

    always_comb begin
        io_rd_c = '0;
        for (int i = 0; i < IO_REGS; i++) begin
            if (word_idx == IDX_W'(i)) io_rd_c = io_words[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_sel_q   <= REG_NONE;
            fault_q    <= 1'b0;
            io_rd_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        if (WAIT_STATES > 0) begin
                            state_q    <= S_WAIT;
                            wait_cnt_q <= WAIT_LOAD;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 4'd0) state_q <= S_RESP;
                    else                    wait_cnt_q <= wait_cnt_q - 4'd1;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Writes and faulted accesses leave the read-data select at NONE
            // so rdata_o reads back as zero.
            if (enter_resp) begin
                fault_q  <= fault_c;
                rd_sel_q <= (cur_we || fault_c) ? REG_NONE : region;
                io_rd_q  <= io_rd_c;
            end
        end
    end

    // Memory arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (enter_resp && reset) begin
            rom_rd_q <= rom_mem[rom_idx];
            ram_rd_q <= ram_mem[ram_idx];
        end
        if (do_write && (region == REG_RAM)) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) ram_mem[ram_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        case (rd_sel_q)
            REG_ROM: rdata_o = rom_rd_q;
            REG_RAM: rdata_o = ram_rd_q;
            REG_IO:  rdata_o = io_rd_q;
            default: rdata_o = '0;
        endcase
    end

    assign ready_o = (state_q == S_RESP);
    assign fault_o = fault_q;

endmodule

// File: tb/tb_memory_system_mm.sv
// Directed testbench for memory_system_mm (WAIT_STATES = 1); expectations
// follow MEMSYS_FAULT_EN when it is defined.
module tb_memory_system_mm;

`ifdef MEMSYS_FAULT_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_i = 1'b0;
    logic         we_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [31:0]  wdata_i = '0;
    logic [3:0]   be_i = '0;
    logic         ready_o;
    logic [31:0]  rdata_o;
    logic         fault_o;
    logic [127:0] io_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_system_mm #(
        .WAIT_STATES (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .ready_o (ready_o),
        .rdata_o (rdata_o),
        .fault_o (fault_o),
        .io_o    (io_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access: returns the cycles from acceptance to ready_o (-1 on timeout).
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd,
                          output logic f, output int lat);
        @(negedge clk);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
        @(posedge clk);
        #1 req_i = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ready_o) break;
        end
        if (!ready_o) lat = -1;
        rd = rdata_o;
        f  = fault_o;
        $display("txn we=%0b addr=%h wdata=%h be=%h -> rdata=%h fault=%0b lat=%0d",
                 w, a, d, b, rd, f, lat);
    endtask

    task automatic run(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_f);
        logic [31:0] rd;
        logic        f;
        int          lat;
        access(w, a, d, b, rd, f, lat);
        check({tag, "_lat"}, 128'(lat), 128'(2));
        check({tag, "_rdata"}, 128'(rd), 128'(exp_rd));
        check({tag, "_fault"}, 128'(f), 128'(exp_f));
    endtask

    initial begin
        int seen;

        repeat (3) @(negedge clk);
        check("rst_ready", 128'(ready_o), 128'(0));
        check("rst_rdata", 128'(rdata_o), 128'(0));
        check("rst_fault", 128'(fault_o), 128'(0));
        check("rst_io", io_o, 128'(0));
        reset = 1'b1;
        @(negedge clk);

        run("ram_wr", 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        check("ready_one_cycle", 128'(ready_o), 128'(0));

        run("ram_rd", 1'b0, 32'h1001_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("rdata_hold", 128'(rdata_o), 128'(32'hDEAD_BEEF));

        run("lane_wr", 1'b1, 32'h1001_0004, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        run("lane_rd", 1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0);

        run("rom_rd0", 1'b0, 32'h0040_0000, 32'h0, 4'hF, 32'hC0DE_0000, 1'b0);
        run("rom_rd1", 1'b0, 32'h0040_0004, 32'h0, 4'h0, 32'hC0DE_0001, 1'b0);
        run("rom_wr", 1'b1, 32'h0040_0000, 32'h1234_5678, 4'hF, 32'h0, FE);
        run("rom_rd_after_wr", 1'b0, 32'h0040_0000, 32'h0, 4'hF, 32'hC0DE_0000, 1'b0);

        run("io_wr", 1'b1, 32'hFFFF_0008, 32'h0000_00A5, 4'hF, 32'h0, 1'b0);
        check("io_bank", io_o, {32'h0, 32'h0000_00A5, 64'h0});
        run("io_rd", 1'b0, 32'hFFFF_0008, 32'h0, 4'hF, 32'h0000_00A5, 1'b0);

        run("ram_wr0", 1'b1, 32'h1001_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        run("unmapped_rd", 1'b0, 32'h2000_0000, 32'h0, 4'hF, 32'h0, FE);
        run("misaligned_rd", 1'b0, 32'h1001_0002, 32'h0, 4'hF,
            FE ? 32'h0 : 32'hCAFE_F00D, FE);
        run("unmapped_wr", 1'b1, 32'h2000_0000, 32'h5A5A_5A5A, 4'hF, 32'h0, FE);

        run("be0_wr", 1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        run("be0_rd", 1'b0, 32'h1001_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);

        // Reset lands in WAIT of a RAM write, ahead of the commit edge.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1001_0004;
        wdata_i = 32'h5555_5555; be_i = 4'hF;
        @(posedge clk);
        #1 req_i = 1'b0;
        #1 reset = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready_o) seen = 1;
        end
        $display("txn reset during WAIT of write to 10010004");
        check("abort_no_ready", 128'(seen), 128'(0));
        check("abort_rdata", 128'(rdata_o), 128'(0));
        check("abort_io", io_o, 128'(0));
        reset = 1'b1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (ready_o) seen = 1;
        end
        check("post_reset_idle", 128'(seen), 128'(0));
        run("abort_rd", 1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
